// File: rtl/mlp_result_streamer_if.sv
// rtl/mlp_result_streamer_if.sv - byte stream between the result streamer and the UART transmitter
interface mlp_result_streamer_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  // Source side: the streamer presents bytes and observes acceptance.
  modport master (output tx_valid, output tx_data, input tx_ready);
  // Sink side: the UART transmitter consumes bytes.
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/mlp_result_streamer.sv
// rtl/mlp_result_streamer.sv - snapshots MLP accumulators and streams them as a byte frame (option: RESULT_STREAMER_CHECKSUM_EN)
module mlp_result_streamer #(
  parameter logic [3:0] DONE_STATE  = 4'd7,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter bit         AUTO_SEND   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             mlp_state,
  input  logic [31:0]            mlp_acc0,
  input  logic [31:0]            mlp_acc1,
  input  logic                   cmd_read,
  mlp_result_streamer_if.master  tx,
  output logic                   busy,
  output logic                   overrun
);

`ifdef RESULT_STREAMER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, HDR, PAY, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

  state_t      state;
  state_t      state_next;
  logic [3:0]  prev_state;
  logic [63:0] snap;
  logic [2:0]  idx;
  logic        trigger;
  logic        valid;
  logic [7:0]  data;
  logic        handshake;
  logic [7:0]  pay_byte;
`ifdef RESULT_STREAMER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // Both trigger sources in one cycle collapse into a single request.
  assign trigger   = cmd_read |
                     (AUTO_SEND && (mlp_state == DONE_STATE) && (prev_state != DONE_STATE));
  assign pay_byte  = snap[{idx, 3'b000} +: 8];
  assign handshake = valid & tx.tx_ready;
  assign tx.tx_valid = valid;
  assign tx.tx_data  = data;
  assign busy      = (state != IDLE);

  // Next-state and stream outputs; data comes straight from the held snapshot so it stays stable under stall.
  always_comb begin
    state_next = state;
    valid      = 1'b0;
    data       = 8'h00;
    case (state)
      IDLE: begin
        if (trigger) state_next = HDR;
      end
      HDR: begin
        valid = 1'b1;
        data  = HEADER_BYTE;
        if (tx.tx_ready) state_next = PAY;
      end
      PAY: begin
        valid = 1'b1;
        data  = pay_byte;
        if (tx.tx_ready && (idx == 3'd7)) begin
`ifdef RESULT_STREAMER_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef RESULT_STREAMER_CHECKSUM_EN
      CSUM: begin
        valid = 1'b1;
        data  = csum;
        if (tx.tx_ready) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State register, edge detector, snapshot/index datapath and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_state <= 4'd0;
      snap       <= 64'd0;
      idx        <= 3'd0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      prev_state <= mlp_state;
      overrun    <= trigger && (state != IDLE);
      if ((state == IDLE) && trigger) begin
        snap <= {mlp_acc1, mlp_acc0};
        idx  <= 3'd0;
      end else if ((state == PAY) && handshake) begin
        idx  <= idx + 3'd1;
      end
    end
  end

`ifdef RESULT_STREAMER_CHECKSUM_EN
  // Running XOR of every byte accepted so far in the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= 8'h00;
    end else if ((state == IDLE) && trigger) begin
      csum <= 8'h00;
    end else if (handshake) begin
      csum <= csum ^ data;
    end
  end
`endif

endmodule
